regbank_write_arbiter: RTL and testbench

Shares the write port of a bank of NUM_REGS enable-gated registers (each with wenable/wdata, cleared on reset) between NUM_REQ requesters, such as the ALU writeback, the load unit and the debug port. Arbitration is round-robin and uses a valid/ready handshake. A requester may lock the port for back-to-back bursts. Accepted writes are registered and presented to the bank one cycle later as a one-hot wenable plus shared wdata.

---
 rtl/regbank_pkg.sv | 22 ++
 rtl/rr_pick.sv | 32 +++
 rtl/regbank_write_arbiter.sv | 137 +++++++++++++
 tb/tb_regbank_write_arbiter.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/regbank_pkg.sv
// Shared types and helpers for the register-bank write arbiter.
package regbank_pkg;

  localparam int OWNER_W  = 3;
  localparam int MAX_REGS = 16;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_t;

  // Returns a one-hot vector with bit idx set, or all zeros when idx >= n.
  function automatic logic [MAX_REGS-1:0] onehot(input int idx, input int n);
    logic [MAX_REGS-1:0] v;
    v = '0;
    for (int k = 0; k < MAX_REGS; k++) begin
      if (k == idx && k < n) v[k] = 1'b1;
    end
    return v;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr, wrapping.
module rr_pick
  import regbank_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0]       req,
  input  logic [OWNER_W-1:0] ptr,
  output logic [N-1:0]       gnt,
  output logic [OWNER_W-1:0] idx,
  output logic               any
);

  // Walk from the farthest slot back to ptr so the nearest request wins last.
  always_comb begin
    int j;
    gnt = '0;
    idx = '0;
    any = 1'b0;
    j   = 0;
    for (int k = N - 1; k >= 0; k--) begin
      j = (int'(ptr) + k) % N;
      if (req[j]) begin
        gnt    = '0;
        gnt[j] = 1'b1;
        idx    = OWNER_W'(j);
        any    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/regbank_write_arbiter.sv
// Round-robin write-port arbiter for an enable-gated register bank, with
// optional burst locking and a lock idle timeout.
//
// state  | meaning
// IDLE   | round-robin grant from rr_ptr among all valid requesters
// LOCKED | only owner may write; released on unlocked write or idle timeout
module regbank_write_arbiter
  import regbank_pkg::*;
#(
  parameter int NUM_REQ      = 4,
  parameter int NUM_REGS     = 8,
  parameter int DATA_SIZE    = 16,
  parameter int ADDR_W       = 4,
  parameter int LOCK_TIMEOUT = 15
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ*ADDR_W-1:0]     req_addr,
  input  logic [NUM_REQ*DATA_SIZE-1:0]  req_data,
  input  logic [NUM_REQ-1:0]            req_lock,
  output logic [NUM_REGS-1:0]           reg_wenable,
  output logic [DATA_SIZE-1:0]          reg_wdata,
  output logic [OWNER_W-1:0]            owner,
  output logic                          locked,
  output logic                          err_oob
);

  arb_state_t          state;
  logic [OWNER_W-1:0]  rr_ptr;
  logic [7:0]          idle_cnt;

  logic [NUM_REQ-1:0]  pick_gnt;
  logic [OWNER_W-1:0]  pick_idx;
  logic                pick_any;
  logic [NUM_REQ-1:0]  owner_mask;
  logic [OWNER_W-1:0]  sel_idx;
  logic [ADDR_W-1:0]   sel_addr;
  logic [DATA_SIZE-1:0] sel_data;
  logic                sel_lock;
  logic                sel_oob;
  logic                xfer;

  function automatic logic [OWNER_W-1:0] wrap_inc(input logic [OWNER_W-1:0] i);
    return (int'(i) >= NUM_REQ - 1) ? '0 : i + 1'b1;
  endfunction

  rr_pick #(.N(NUM_REQ)) u_pick (
    .req (req_valid),
    .ptr (rr_ptr),
    .gnt (pick_gnt),
    .idx (pick_idx),
    .any (pick_any)
  );

  assign sel_idx = (state == IDLE) ? pick_idx : owner;

  // Decode owner and mux the selected requester's fields without narrow indexing.
  always_comb begin
    owner_mask = '0;
    sel_addr   = '0;
    sel_data   = '0;
    sel_lock   = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (OWNER_W'(k) == owner) owner_mask[k] = 1'b1;
      if (OWNER_W'(k) == sel_idx) begin
        sel_addr = req_addr[k*ADDR_W +: ADDR_W];
        sel_data = req_data[k*DATA_SIZE +: DATA_SIZE];
        sel_lock = req_lock[k];
      end
    end
  end

  assign req_ready = (state == IDLE) ? pick_gnt : (req_valid & owner_mask);
  assign xfer      = (state == IDLE) ? pick_any : |(req_valid & owner_mask);
  assign sel_oob   = (int'(sel_addr) >= NUM_REGS);

  always_ff @(posedge clk) begin
    if (rst) begin
      reg_wenable <= '0;
      reg_wdata   <= '0;
      err_oob     <= 1'b0;
      owner       <= '0;
      locked      <= 1'b0;
      rr_ptr      <= '0;
      state       <= IDLE;
      idle_cnt    <= '0;
    end else begin
      reg_wenable <= '0;
      err_oob     <= 1'b0;

      if (xfer) begin
        owner <= sel_idx;
        if (sel_oob) begin
          err_oob <= 1'b1;
        end else begin
          reg_wenable <= NUM_REGS'(onehot(int'(sel_addr), NUM_REGS));
          reg_wdata   <= sel_data;
        end
      end

      case (state)
        IDLE: begin
          if (xfer) begin
            if (sel_lock) begin
              state    <= LOCKED;
              locked   <= 1'b1;
              idle_cnt <= '0;
            end else begin
              rr_ptr <= wrap_inc(sel_idx);
            end
          end
        end
        LOCKED: begin
          if (xfer) begin
            if (sel_lock) begin
              idle_cnt <= '0;
            end else begin
              state  <= IDLE;
              locked <= 1'b0;
              rr_ptr <= wrap_inc(owner);
            end
          end else if (idle_cnt >= 8'(LOCK_TIMEOUT - 1)) begin
            state  <= IDLE;
            locked <= 1'b0;
            rr_ptr <= wrap_inc(owner);
          end else begin
            idle_cnt <= idle_cnt + 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_regbank_write_arbiter.sv
// Directed bench for regbank_write_arbiter: grant order, locking, timeout,
// out-of-range writes and reset during a transfer.
module tb_regbank_write_arbiter;

  localparam int NREQ  = 4;
  localparam int NREGS = 8;
  localparam int DW    = 16;
  localparam int AW    = 4;
  localparam int LTO   = 4;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic [NREQ-1:0]      req_valid = '0;
  logic [NREQ-1:0]      req_ready;
  logic [NREQ*AW-1:0]   req_addr = '0;
  logic [NREQ*DW-1:0]   req_data = '0;
  logic [NREQ-1:0]      req_lock = '0;
  logic [NREGS-1:0]     reg_wenable;
  logic [DW-1:0]        reg_wdata;
  logic [2:0]           owner;
  logic                 locked;
  logic                 err_oob;

  int n_checks = 0;
  int n_fail   = 0;

  regbank_write_arbiter #(
    .NUM_REQ(NREQ), .NUM_REGS(NREGS), .DATA_SIZE(DW), .ADDR_W(AW), .LOCK_TIMEOUT(LTO)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_data(req_data), .req_lock(req_lock),
    .reg_wenable(reg_wenable), .reg_wdata(reg_wdata),
    .owner(owner), .locked(locked), .err_oob(err_oob)
  );

  always #5 clk = ~clk;

  // Requester contract: a waiting request keeps its fields stable.
  generate
    for (genvar g = 0; g < NREQ; g++) begin : g_contract
      a_stable: assert property (@(posedge clk) disable iff (rst)
        (req_valid[g] && !req_ready[g]) |=>
          (!req_valid[g] || ($stable(req_addr[g*AW +: AW]) &&
                             $stable(req_data[g*DW +: DW]) &&
                             $stable(req_lock[g]))));
    end
  endgenerate

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 'h%0h, expected 'h%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic set_req(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_addr[i*AW +: AW] = a;
    req_data[i*DW +: DW] = d;
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    req_valid = '0;
    req_lock  = '0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got time limit, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset state
    do_reset();
    chk("rst_wen",   32'(reg_wenable), 0);
    chk("rst_wdata", 32'(reg_wdata),   0);
    chk("rst_oob",   32'(err_oob),     0);
    chk("rst_owner", 32'(owner),       0);
    chk("rst_lock",  32'(locked),      0);
    chk("rst_rdy",   32'(req_ready),   0);

    // Single write, one-cycle latency
    set_req(0, 4'd3, 16'hBEEF);
    req_valid = 4'b0001;
    settle();
    chk("t1_rdy", 32'(req_ready), 'h1);
    tick();
    req_valid = '0;
    chk("t1_wen",   32'(reg_wenable), 'h08);
    chk("t1_wdata", 32'(reg_wdata),   'hBEEF);
    tick();
    chk("t1_wen_off",  32'(reg_wenable), 0);
    chk("t1_wdata_hd", 32'(reg_wdata),   'hBEEF);

    // Round-robin with all requesters valid
    do_reset();
    for (int i = 0; i < NREQ; i++) set_req(i, AW'(i), DW'('hA000 + i));
    req_valid = 4'hF;
    for (int k = 0; k < 8; k++) begin
      settle();
      chk("t2_rdy", 32'(req_ready), 1 << (k % 4));
      tick();
      chk("t2_wen",   32'(reg_wenable), 1 << (k % 4));
      chk("t2_wdata", 32'(reg_wdata),   'hA000 + (k % 4));
      chk("t2_owner", 32'(owner),       k % 4);
    end
    settle();
    chk("t2_wrap", 32'(req_ready), 'h1);
    req_valid = '0;

    // Locked burst by req2 while others wait
    do_reset();
    for (int i = 0; i < NREQ; i++) set_req(i, AW'(i), DW'('hC000 + i));
    req_valid = 4'b0010;
    settle();
    chk("t3_pre_rdy", 32'(req_ready), 'h2);
    tick();
    req_valid = 4'hF;
    req_lock  = 4'b0100;
    settle();
    chk("t3_rdy_a",  32'(req_ready),   'h4);
    chk("t3_wen_p",  32'(reg_wenable), 'h2);
    chk("t3_own_p",  32'(owner),       1);
    tick();
    chk("t3_lock_1", 32'(locked),      1);
    chk("t3_wen_1",  32'(reg_wenable), 'h4);
    chk("t3_own_1",  32'(owner),       2);
    settle();
    chk("t3_rdy_1",  32'(req_ready),   'h4);
    tick();
    chk("t3_lock_2", 32'(locked),      1);
    chk("t3_wen_2",  32'(reg_wenable), 'h4);
    req_lock = '0;
    settle();
    chk("t3_rdy_2",  32'(req_ready),   'h4);
    tick();
    chk("t3_lock_3", 32'(locked),      0);
    chk("t3_wen_3",  32'(reg_wenable), 'h4);
    settle();
    chk("t3_rdy_3",  32'(req_ready),   'h8);
    tick();
    chk("t3_wen_4",  32'(reg_wenable), 'h8);
    chk("t3_own_4",  32'(owner),       3);
    req_valid = '0;

    // Lock idle timeout
    do_reset();
    set_req(0, 4'd5, 16'hD000);
    set_req(1, 4'd6, 16'hD001);
    req_valid = 4'b0010;
    req_lock  = 4'b0010;
    settle();
    chk("t4_rdy_lk", 32'(req_ready), 'h2);
    tick();
    req_valid = 4'b0001;
    req_lock  = '0;
    chk("t4_wen_lk", 32'(reg_wenable), 'h40);
    for (int k = 1; k <= LTO; k++) begin
      settle();
      chk("t4_blocked", 32'(req_ready), 0);
      chk("t4_locked",  32'(locked),    1);
      tick();
    end
    settle();
    chk("t4_rdy_rel",  32'(req_ready), 'h1);
    chk("t4_lock_rel", 32'(locked),    0);
    tick();
    chk("t4_wen_0",   32'(reg_wenable), 'h20);
    chk("t4_own_0",   32'(owner),       0);
    req_valid = '0;

    // Out-of-range address
    do_reset();
    set_req(0, 4'd2, 16'h1234);
    req_valid = 4'b0001;
    settle();
    chk("t5_rdy_a", 32'(req_ready), 'h1);
    tick();
    set_req(0, 4'd9, 16'h5555);
    settle();
    chk("t5_rdy_b",   32'(req_ready),   'h1);
    chk("t5_wen_a",   32'(reg_wenable), 'h04);
    chk("t5_wdata_a", 32'(reg_wdata),   'h1234);
    chk("t5_oob_a",   32'(err_oob),     0);
    tick();
    req_valid = '0;
    chk("t5_wen_b",   32'(reg_wenable), 0);
    chk("t5_oob_b",   32'(err_oob),     1);
    chk("t5_wdata_b", 32'(reg_wdata),   'h1234);
    tick();
    chk("t5_oob_c",   32'(err_oob),     0);

    // Reset coinciding with a transfer
    do_reset();
    set_req(0, 4'd0, 16'hE000);
    set_req(1, 4'd1, 16'hE001);
    set_req(2, 4'd5, 16'hE002);
    req_valid = 4'b0010;
    settle();
    chk("t6_rdy_1", 32'(req_ready), 'h2);
    tick();
    req_valid = 4'b0100;
    req_lock  = 4'b0100;
    settle();
    chk("t6_rdy_2", 32'(req_ready), 'h4);
    tick();
    rst = 1'b1;
    settle();
    chk("t6_rdy_n",  32'(req_ready), 'h4);
    chk("t6_lock_n", 32'(locked),    1);
    chk("t6_own_n",  32'(owner),     2);
    tick();
    rst       = 1'b0;
    req_valid = 4'hF;
    req_lock  = '0;
    chk("t6_wen",   32'(reg_wenable), 0);
    chk("t6_owner", 32'(owner),       0);
    chk("t6_lock",  32'(locked),      0);
    settle();
    chk("t6_first", 32'(req_ready),   'h1);
    tick();
    req_valid = '0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
